// File: rtl/datamem_arb_pkg.sv
// Shared types and constants for the DataMem arbiter and its round-robin picker.
package datamem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbState_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/datamem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the master that was not last granted wins.
module rr_arb2
    import datamem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lastGrant,
    output logic       grantValid,
    output logic       grantIdx
);

    always_comb begin
        grantValid = |req;
        grantIdx   = M0;
        case (req)
            2'b01:   grantIdx = M0;
            2'b10:   grantIdx = M1;
            2'b11:   grantIdx = ~lastGrant;
            default: grantIdx = M0;
        endcase
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-master round-robin arbiter in front of the single DataMem port, one access outstanding.
// Optional access timeout is built only when DATAMEM_ARB_TIMEOUT_EN is defined.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iM0Req,
    input  logic              iM0Wr,
    input  logic [ADDR_W-1:0] iM0Addr,
    input  logic [DATA_W-1:0] iM0WrData,
    input  logic              iM1Req,
    input  logic              iM1Wr,
    input  logic [ADDR_W-1:0] iM1Addr,
    input  logic [DATA_W-1:0] iM1WrData,
    output logic              oM0Ack,
    output logic [DATA_W-1:0] oM0RdData,
    output logic              oM0Err,
    output logic              oM1Ack,
    output logic [DATA_W-1:0] oM1RdData,
    output logic              oM1Err,
    output logic              oMemRd,
    output logic              oMemWr,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWrData,
    input  logic [DATA_W-1:0] iMemRdData,
    input  logic              iMemAccessable,
    output logic              oBusy
);

    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arbState_e         state;
    logic              lastGrant;
    logic              ownerQ;
    logic              wrQ;
    logic              grantValid;
    logic              grantIdx;
    logic              selWr;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWrData;
    logic              timeoutHit;

    rr_arb2 uRrArb (
        .req        ({iM1Req, iM0Req}),
        .lastGrant  (lastGrant),
        .grantValid (grantValid),
        .grantIdx   (grantIdx)
    );

    always_comb begin
        selWr     = (grantIdx == M1) ? iM1Wr     : iM0Wr;
        selAddr   = (grantIdx == M1) ? iM1Addr   : iM0Addr;
        selWrData = (grantIdx == M1) ? iM1WrData : iM0WrData;
    end

`ifdef DATAMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] accessCnt;
    // Count holds the number of ACCESS cycles already elapsed, so the limit edge is at count-1.
    assign timeoutHit = (accessCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeoutHit = 1'b0;
    assign oM0Err     = 1'b0;
    assign oM1Err     = 1'b0;
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state      <= IDLE;
            lastGrant  <= M1;
            ownerQ     <= M0;
            wrQ        <= 1'b0;
            oM0Ack     <= 1'b0;
            oM1Ack     <= 1'b0;
            oM0RdData  <= '0;
            oM1RdData  <= '0;
            oMemRd     <= 1'b0;
            oMemWr     <= 1'b0;
            oMemAddr   <= '0;
            oMemWrData <= '0;
            oBusy      <= 1'b0;
`ifdef DATAMEM_ARB_TIMEOUT_EN
            accessCnt  <= '0;
            oM0Err     <= 1'b0;
            oM1Err     <= 1'b0;
`endif
        end else begin
            oM0Ack <= 1'b0;
            oM1Ack <= 1'b0;
`ifdef DATAMEM_ARB_TIMEOUT_EN
            oM0Err <= 1'b0;
            oM1Err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        ownerQ     <= grantIdx;
                        lastGrant  <= grantIdx;
                        wrQ        <= selWr;
                        oMemRd     <= ~selWr;
                        oMemWr     <= selWr;
                        oMemAddr   <= selAddr;
                        oMemWrData <= selWrData;
                        oBusy      <= 1'b1;
                        state      <= ACCESS;
`ifdef DATAMEM_ARB_TIMEOUT_EN
                        accessCnt  <= '0;
`endif
                    end
                end
                ACCESS: begin
                    if (iMemAccessable) begin
                        if (!wrQ) begin
                            if (ownerQ == M1) oM1RdData <= iMemRdData;
                            else              oM0RdData <= iMemRdData;
                        end
                        oM0Ack <= (ownerQ == M0);
                        oM1Ack <= (ownerQ == M1);
                        oMemRd <= 1'b0;
                        oMemWr <= 1'b0;
                        state  <= DONE;
                    end else if (timeoutHit) begin
                        oM0Ack <= (ownerQ == M0);
                        oM1Ack <= (ownerQ == M1);
`ifdef DATAMEM_ARB_TIMEOUT_EN
                        oM0Err <= (ownerQ == M0);
                        oM1Err <= (ownerQ == M1);
`endif
                        oMemRd <= 1'b0;
                        oMemWr <= 1'b0;
                        state  <= DONE;
                    end else begin
`ifdef DATAMEM_ARB_TIMEOUT_EN
                        accessCnt <= accessCnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    oMemRd <= 1'b0;
                    oMemWr <= 1'b0;
                    oBusy  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed self-checking bench for datamem_arbiter with a small behavioural DataMem model.
module tb_datamem_arbiter;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iM0Req = 1'b0, iM0Wr = 1'b0;
    logic [31:0] iM0Addr = '0, iM0WrData = '0;
    logic        iM1Req = 1'b0, iM1Wr = 1'b0;
    logic [31:0] iM1Addr = '0, iM1WrData = '0;
    logic        oM0Ack, oM0Err, oM1Ack, oM1Err;
    logic [31:0] oM0RdData, oM1RdData;
    logic        oMemRd, oMemWr, oBusy;
    logic [31:0] oMemAddr, oMemWrData, iMemRdData;
    logic        iMemAccessable = 1'b1;

    logic [31:0] mem [0:255];
    int checks = 0;
    int failures = 0;

    always #5 iClk = ~iClk;

    assign iMemRdData = mem[oMemAddr[7:0]];
    always @(posedge iClk) if (oMemWr && iMemAccessable) mem[oMemAddr[7:0]] <= oMemWrData;

    datamem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .iM0Req(iM0Req), .iM0Wr(iM0Wr), .iM0Addr(iM0Addr), .iM0WrData(iM0WrData),
        .iM1Req(iM1Req), .iM1Wr(iM1Wr), .iM1Addr(iM1Addr), .iM1WrData(iM1WrData),
        .oM0Ack(oM0Ack), .oM0RdData(oM0RdData), .oM0Err(oM0Err),
        .oM1Ack(oM1Ack), .oM1RdData(oM1RdData), .oM1Err(oM1Err),
        .oMemRd(oMemRd), .oMemWr(oMemWr), .oMemAddr(oMemAddr), .oMemWrData(oMemWrData),
        .iMemRdData(iMemRdData), .iMemAccessable(iMemAccessable), .oBusy(oBusy)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    int a0, a1, bothAck, nAck;
    logic [3:0] ackOrder;

    initial begin
        mem[8'h10] <= 32'hDEADBEEF;
        mem[8'h20] <= 32'h0;
        mem[8'h40] <= 32'h0;
        mem[8'h60] <= 32'h00000077;
        mem[8'h80] <= 32'h00000088;
        #1;
        checkEq("rst_busy", oBusy, 0);
        checkEq("rst_strobes", {oMemRd, oMemWr}, 0);
        checkEq("rst_acks", {oM0Ack, oM1Ack, oM0Err, oM1Err}, 0);
        checkEq("rst_addr", oMemAddr, 0);
        checkEq("rst_wdata", oMemWrData, 0);
        checkEq("rst_rd0", oM0RdData, 0);
        checkEq("rst_rd1", oM1RdData, 0);
        tick();
        iRst_n = 1'b1;

        // Single read by M0
        iM0Req = 1; iM0Wr = 0; iM0Addr = 32'h10;
        tick();
        checkEq("rd_busy", oBusy, 1);
        checkEq("rd_strobe", {oMemRd, oMemWr}, 2'b10);
        checkEq("rd_addr", oMemAddr, 32'h10);
        checkEq("rd_noack", oM0Ack, 0);
        tick();
        checkEq("rd_ack", {oM0Ack, oM1Ack}, 2'b10);
        checkEq("rd_err", oM0Err, 0);
        checkEq("rd_data", oM0RdData, 32'hDEADBEEF);
        checkEq("rd_strobe_off", oMemRd, 0);
        iM0Req = 0;
        tick();
        checkEq("rd_ack_pulse", oM0Ack, 0);
        checkEq("rd_idle", oBusy, 0);

        // Simultaneous requests from a fresh reset: M0 write, then M1 read of the same word
        iRst_n = 0; tick(); iRst_n = 1;
        iM0Req = 1; iM0Wr = 1; iM0Addr = 32'h20; iM0WrData = 32'h1234;
        iM1Req = 1; iM1Wr = 0; iM1Addr = 32'h20;
        a0 = -1; a1 = -1; bothAck = 0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 1) checkEq("tie_m0_first", {oMemWr, oMemAddr[7:0]}, {1'b1, 8'h20});
            if (n == 4) checkEq("tie_m1_second", {oMemRd, oMemAddr[7:0]}, {1'b1, 8'h20});
            if (oM0Ack && oM1Ack) bothAck++;
            if (oM0Ack) begin a0 = n; iM0Req = 0; end
            if (oM1Ack) begin a1 = n; iM1Req = 0; end
        end
        checkEq("tie_ack0_cycle", a0, 2);
        checkEq("tie_ack1_cycle", a1, 5);
        checkEq("tie_both_ack", bothAck, 0);
        checkEq("tie_rd1", oM1RdData, 32'h1234);
        checkEq("tie_rd0_untouched", oM0RdData, 0);

        // Wait states on an M1 write; inputs changed after grant must not leak through
        iMemAccessable = 0;
        iM1Req = 1; iM1Wr = 1; iM1Addr = 32'h40; iM1WrData = 32'hA5A5A5A5;
        tick();
        iM1Addr = 32'h99; iM1WrData = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checkEq("ws_wr", {oMemRd, oMemWr}, 2'b01);
            checkEq("ws_addr", oMemAddr, 32'h40);
            checkEq("ws_wdata", oMemWrData, 32'hA5A5A5A5);
            checkEq("ws_noack", oM1Ack, 0);
            if (i == 4) iMemAccessable = 1;
            tick();
        end
        checkEq("ws_ack", {oM0Ack, oM1Ack}, 2'b01);
        checkEq("ws_strobe_off", oMemWr, 0);
        checkEq("ws_mem", mem[8'h40], 32'hA5A5A5A5);
        checkEq("ws_rd1_kept", oM1RdData, 32'h1234);
        iM1Req = 0;
        tick();

        // Continuous contention, last grant was M1
        iM0Req = 1; iM0Wr = 0; iM0Addr = 32'h60;
        iM1Req = 1; iM1Wr = 0; iM1Addr = 32'h80;
        nAck = 0; bothAck = 0; ackOrder = '0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (oM0Ack && oM1Ack) bothAck++;
            else if (oM0Ack || oM1Ack) begin
                if (nAck < 4) ackOrder[nAck] = oM1Ack;
                nAck++;
            end
        end
        checkEq("rr_count", nAck, 4);
        checkEq("rr_order", ackOrder, 4'b1010);
        checkEq("rr_both", bothAck, 0);
        checkEq("rr_rd0", oM0RdData, 32'h77);
        checkEq("rr_rd1", oM1RdData, 32'h88);
        iM0Req = 0; iM1Req = 0;
        tick();

        // Reset while M0 sits in ACCESS
        iMemAccessable = 0;
        iM0Req = 1; iM0Wr = 0; iM0Addr = 32'h60;
        tick();
        tick();
        checkEq("mr_pre_strobe", oMemRd, 1);
        iRst_n = 0;
        #1;
        checkEq("mr_strobe_drop", {oMemRd, oMemWr}, 0);
        checkEq("mr_busy_drop", oBusy, 0);
        iMemAccessable = 1;
        tick();
        checkEq("mr_no_ack", {oM0Ack, oM1Ack}, 0);
        tick();
        checkEq("mr_no_ack2", {oM0Ack, oM1Ack}, 0);
        checkEq("mr_rd0_clr", oM0RdData, 0);
        iM1Req = 1; iM1Wr = 0; iM1Addr = 32'h80;
        iRst_n = 1;
        tick();
        checkEq("mr_tie_m0", oMemAddr, 32'h60);
        tick();
        checkEq("mr_ack0", {oM0Ack, oM1Ack}, 2'b10);
        checkEq("mr_rd0", oM0RdData, 32'h77);
        iM0Req = 0; iM1Req = 0;
        tick();
        tick();
        checkEq("mr_dropped_req", oBusy, 0);

`ifdef DATAMEM_ARB_TIMEOUT_EN
        // Stuck DataMem: M0 read aborts after 4 ACCESS cycles
        iMemAccessable = 0;
        iM0Req = 1; iM0Wr = 0; iM0Addr = 32'h10;
        tick();
        for (int i = 0; i < 4; i++) begin
            checkEq("to_wait_busy", oBusy, 1);
            checkEq("to_wait_noack", {oM0Ack, oM0Err}, 0);
            tick();
        end
        checkEq("to_ack_err", {oM0Ack, oM0Err, oM1Ack, oM1Err}, 4'b1100);
        checkEq("to_rd_kept", oM0RdData, 32'h77);
        checkEq("to_strobe_off", oMemRd, 0);
        iM0Req = 0;
        tick();
        checkEq("to_pulse", {oM0Ack, oM0Err}, 0);
        checkEq("to_idle", oBusy, 0);
        iMemAccessable = 1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Shares the single DataMem port between two requesters: M0 = singcyc_core data port, M1 = debug/program-loader port.
- Sits between the requesters and DataMem. Drives DataMem rd/wr/addr/wdata and waits on its accessable signal.
- Returns a one-cycle ack and registered read data to whichever requester was granted.
- Uses round-robin arbitration with one outstanding access at a time.

Parameters:
- ADDR_W, 32, address width for both masters and memory.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort. Used only when DATAMEM_ARB_TIMEOUT_EN is defined.

Ports:
- iClk  in  1  clock.
- iRst_n  in  1  asynchronous, active-low reset.
- iM0Req, iM1Req  in  1  access request; held high until ack.
- iM0Wr, iM1Wr  in  1  1 = write, 0 = read; valid with req.
- iM0Addr, iM1Addr  in  ADDR_W  byte address.
- iM0WrData, iM1WrData  in  DATA_W  write data.
- oM0Ack, oM1Ack  out  1  one-cycle completion pulse.
- oM0RdData, oM1RdData  out  DATA_W  registered read data; valid from ack onward.
- oM0Err, oM1Err  out  1  timeout abort flag; pulses with ack.
- oMemRd, oMemWr  out  1  DataMem strobes.
- oMemAddr  out  ADDR_W  DataMem address.
- oMemWrData  out  DATA_W  DataMem write data.
- iMemRdData  in  DATA_W  DataMem read data.
- iMemAccessable  in  1  DataMem ready/complete for the current strobe.
- oBusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, iRst_n = 0):
  - state = IDLE; last_grant = M1, so M0 wins the first tie.
  - All acks, errs, strobes and oBusy = 0.
  - oMemAddr, oMemWrData and both RdData outputs = 0.
  - Reset during ACCESS drops strobes immediately. The access is abandoned with no ack.
- FSM IDLE -> ACCESS -> DONE -> IDLE:
  - IDLE: sample requests at the clock edge.
    - Exactly one req high: grant that master.
    - Both high: grant the master that is not last_grant.
    - On grant, latch owner, wr, addr and wdata into registers, update last_grant, go to ACCESS.
    - No req: stay in IDLE.
  - ACCESS: drive oMemRd = ~wr_q and oMemWr = wr_q from registered copies, plus oMemAddr and oMemWrData.
    - When iMemAccessable = 1 at an edge: if read, capture iMemRdData into the owner's RdData register; go to DONE.
    - Otherwise stay in ACCESS with strobes held.
  - DONE: owner's Ack = 1 for exactly this cycle; strobes = 0; no arbitration this cycle.
    - Next state is IDLE unconditionally.
- Latency and throughput:
  - Request sampled at edge k gives ACCESS at k+1.
  - Minimum: accessable seen at edge k+2 gives ack during cycle k+2..k+3.
  - Minimum request-to-ack is 2 cycles; at best one access per 3 cycles.
- Request and data rules:
  - Master inputs are latched at grant. Changing addr or data afterwards has no effect.
  - A req that drops before grant is never serviced.
  - A req that drops during ACCESS does not cancel; the access completes and ack still pulses.
  - A master keeping req high through DONE is re-arbitrated in IDLE. With the other master also requesting, it loses due to round-robin, so no starvation.
  - Non-owner RdData registers hold their value. A write never alters either RdData register.
- oM0Err and oM1Err are 0 unless the optional feature is enabled.

Optional Feature:
- Macro DATAMEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When the count reaches TIMEOUT_CYCLES with iMemAccessable still 0: drop strobes, go to DONE, pulse the owner's Ack and Err together.
  - RdData is left unchanged on timeout.
  - iMemAccessable = 1 on the same edge as the limit wins: normal completion, Err = 0.
- Undefined:
  - No counter is built; ACCESS waits indefinitely.
  - Err outputs are tied to 0.

Decomposition:
- Package datamem_arb_pkg: state encodings (IDLE, ACCESS, DONE), master index constants M0 = 0 and M1 = 1, default TIMEOUT_CYCLES.
- One sub-module, rr_arb2: combinational two-way round-robin pick.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant_valid, grant_idx.
- FSM and datapath registers stay in datamem_arbiter.

Test Plan:
- Single read: M0 reads addr 0x10 (mem holds 0xDEADBEEF), accessable tied 1.
  - oMemRd high 1 cycle with oMemAddr = 0x10.
  - oM0Ack 2 cycles after req; oM0RdData = 0xDEADBEEF.
- Simultaneous requests from reset: M0 writes 0x1234 to 0x20, M1 reads 0x20, both reqs held.
  - M0 served first, then M1; oM1RdData = 0x1234.
  - Acks 3 cycles apart, never in the same cycle.
- Wait states: accessable held low 4 cycles during an M1 write of 0xA5A5A5A5 to 0x40.
  - oMemWr, oMemAddr and oMemWrData stable for all 5 ACCESS cycles.
  - oM1Ack one cycle after accessable rises.
- Continuous contention: both reqs held high for 12 cycles.
  - Grants alternate M0, M1, M0, M1; neither master gets two consecutive grants.
- Reset mid-access: assert iRst_n = 0 during ACCESS.
  - Strobes drop asynchronously; no ack.
  - After release, oBusy = 0 and the first tie goes to M0.
- With DATAMEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4: accessable stuck at 0 on an M0 read.
  - After 4 ACCESS cycles, oM0Ack = oM0Err = 1 for one cycle.
  - oM0RdData unchanged; the FSM returns to IDLE.
